// File: rtl/falling_column_game_if.sv
// Player/display bundle for falling_column_game: switches and start in, column buses and status out.
// The lives signal exists only when FALLING_COLUMN_LIVES_EN is defined.
interface falling_column_game_if #(
    parameter int NUM_COLS  = 3,
    parameter int BIT_WIDTH = 8,
    parameter int YPOS_W    = 5,
    parameter int SCORE_W   = 16
);
    logic                          start;
    logic [BIT_WIDTH-1:0]          user_input;
    logic [NUM_COLS*BIT_WIDTH-1:0] letters;
    logic [NUM_COLS*YPOS_W-1:0]    ypos;
    logic [NUM_COLS-1:0]           active;
    logic [SCORE_W-1:0]            score;
    logic                          correct;
    logic                          playing;
    logic                          game_over;
`ifdef FALLING_COLUMN_LIVES_EN
    logic [3:0]                    lives;
`endif

    modport master (
        output start, user_input,
        input  letters, ypos, active, score, correct, playing, game_over
`ifdef FALLING_COLUMN_LIVES_EN
        , input lives
`endif
    );

    modport slave (
        input  start, user_input,
        output letters, ypos, active, score, correct, playing, game_over
`ifdef FALLING_COLUMN_LIVES_EN
        , output lives
`endif
    );
endinterface

// File: rtl/falling_column_game.sv
// Multi-column falling-letter game: LFSR spawning, matching, scoring, speed ramp, start/over flow.
// Define FALLING_COLUMN_LIVES_EN to add a lives counter (parameter LIVES, bus.lives).
module falling_column_game #(
    parameter int          NUM_COLS      = 3,
    parameter int          BIT_WIDTH     = 8,
    parameter int          YPOS_W        = 5,
    parameter int          BOTTOM_ROW    = 21,
    parameter int          TICK_DIV_INIT = 25000000,
    parameter int          TICK_DIV_MIN  = 5000000,
    parameter int          SPEEDUP_STEP  = 1000000,
    parameter int          SPEEDUP_EVERY = 8,
    parameter int          SPAWN_GAP     = 4,
    parameter int          SCORE_W       = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
`ifdef FALLING_COLUMN_LIVES_EN
    ,
    parameter int          LIVES         = 3
`endif
) (
    input  logic                 clock,
    input  logic                 reset_signal,
    falling_column_game_if.slave bus
);
    localparam int PER_W = $clog2(TICK_DIV_INIT + 1);
    localparam int SPN_W = $clog2(SPAWN_GAP + 1);
    localparam int SPD_W = $clog2(SPEEDUP_EVERY + 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

    state_t               state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [PER_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [PER_W-1:0]     cur_per_q, cur_per_d;
    logic [PER_W-1:0]     next_per_q, next_per_d;
    logic [SPN_W-1:0]     spawn_cnt_q, spawn_cnt_d;
    logic [SPD_W-1:0]     spd_cnt_q, spd_cnt_d;
    logic                 armed_q, armed_d;
    logic [BIT_WIDTH-1:0] armed_val_q, armed_val_d;
    logic                 start_prev_q;
    logic [BIT_WIDTH-1:0] letters_q [NUM_COLS];
    logic [BIT_WIDTH-1:0] letters_d [NUM_COLS];
    logic [YPOS_W-1:0]    ypos_q [NUM_COLS];
    logic [YPOS_W-1:0]    ypos_d [NUM_COLS];
    logic [NUM_COLS-1:0]  active_q, active_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 correct_q, correct_d;
`ifdef FALLING_COLUMN_LIVES_EN
    logic [3:0]           lives_q, lives_d;
`endif

    logic [NUM_COLS-1:0]  hit, at_bottom, missed, match_oh, free_oh;
    logic                 tick, miss, miss_fatal, start_game;
    logic [BIT_WIDTH-1:0] spawn_letter;

    assign tick = (state_q == S_PLAY) && (tick_cnt_q == cur_per_q - PER_W'(1));
    assign start_game = ((state_q == S_IDLE) && bus.start) ||
                        ((state_q == S_OVER) && bus.start && !start_prev_q);
    assign spawn_letter = (lfsr_q[BIT_WIDTH-1:0] == '0) ? BIT_WIDTH'(1) : lfsr_q[BIT_WIDTH-1:0];

    // Lowest set bit of hit wins the match; lowest clear bit of active_q is the spawn slot.
    assign match_oh = (armed_q && (state_q == S_PLAY)) ? (hit & (~hit + NUM_COLS'(1))) : '0;
    assign free_oh  = ~active_q & (active_q + NUM_COLS'(1));
    assign miss     = |missed;

`ifdef FALLING_COLUMN_LIVES_EN
    assign miss_fatal = miss && (lives_q <= 4'd1);
    assign bus.lives  = lives_q;
`else
    assign miss_fatal = miss;
`endif

    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
        assign hit[gi]       = active_q[gi] && (letters_q[gi] == bus.user_input);
        assign at_bottom[gi] = active_q[gi] && (ypos_q[gi] == YPOS_W'(BOTTOM_ROW));
        assign missed[gi]    = tick && at_bottom[gi] && !match_oh[gi];
        assign bus.letters[gi*BIT_WIDTH +: BIT_WIDTH] = letters_q[gi];
        assign bus.ypos[gi*YPOS_W +: YPOS_W]          = ypos_q[gi];
    end

    assign bus.active    = active_q;
    assign bus.score     = score_q;
    assign bus.correct   = correct_q;
    assign bus.playing   = (state_q == S_PLAY);
    assign bus.game_over = (state_q == S_OVER);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        tick_cnt_d  = tick_cnt_q;
        cur_per_d   = cur_per_q;
        next_per_d  = next_per_q;
        spawn_cnt_d = spawn_cnt_q;
        spd_cnt_d   = spd_cnt_q;
        armed_d     = armed_q;
        armed_val_d = armed_val_q;
        letters_d   = letters_q;
        ypos_d      = ypos_q;
        active_d    = active_q;
        score_d     = score_q;
        correct_d   = 1'b0;
`ifdef FALLING_COLUMN_LIVES_EN
        lives_d     = lives_q;
`endif

        if (!armed_q && (bus.user_input != armed_val_q)) begin
            armed_d = 1'b1;
        end

        if (start_game) begin
            state_d     = S_PLAY;
            tick_cnt_d  = '0;
            cur_per_d   = PER_W'(TICK_DIV_INIT);
            next_per_d  = PER_W'(TICK_DIV_INIT);
            spawn_cnt_d = SPN_W'(SPAWN_GAP - 1);
            spd_cnt_d   = '0;
            armed_d     = 1'b1;
            active_d    = '0;
            score_d     = '0;
            for (int i = 0; i < NUM_COLS; i++) begin
                letters_d[i] = '0;
                ypos_d[i]    = '0;
            end
`ifdef FALLING_COLUMN_LIVES_EN
            lives_d     = 4'(LIVES);
`endif
        end else if (state_q == S_PLAY) begin
            // A shortened period is latched only at the wrap so the running count never overshoots.
            if (tick) begin
                tick_cnt_d = '0;
                cur_per_d  = next_per_q;
            end else begin
                tick_cnt_d = tick_cnt_q + PER_W'(1);
            end

            if (|match_oh) begin
                correct_d   = 1'b1;
                armed_d     = 1'b0;
                armed_val_d = bus.user_input;
                if (!(&score_q)) begin
                    score_d = score_q + SCORE_W'(1);
                    if (spd_cnt_q == SPD_W'(SPEEDUP_EVERY - 1)) begin
                        spd_cnt_d = '0;
                        if (int'(next_per_q) >= TICK_DIV_MIN + SPEEDUP_STEP)
                            next_per_d = next_per_q - PER_W'(SPEEDUP_STEP);
                        else
                            next_per_d = PER_W'(TICK_DIV_MIN);
                    end else begin
                        spd_cnt_d = spd_cnt_q + SPD_W'(1);
                    end
                end
            end
            for (int i = 0; i < NUM_COLS; i++) begin
                if (match_oh[i]) begin
                    active_d[i] = 1'b0;
                    ypos_d[i]   = '0;
                end
            end

`ifdef FALLING_COLUMN_LIVES_EN
            if (miss) lives_d = lives_q - 4'd1;
`endif
            if (tick) begin
                if (miss_fatal) begin
                    state_d = S_OVER;
                end else begin
                    for (int i = 0; i < NUM_COLS; i++) begin
                        if (missed[i]) begin
                            active_d[i] = 1'b0;
                            ypos_d[i]   = '0;
                        end else if (active_q[i] && !match_oh[i]) begin
                            ypos_d[i] = ypos_q[i] + YPOS_W'(1);
                        end
                    end
                    if (spawn_cnt_q >= SPN_W'(SPAWN_GAP - 1)) begin
                        if (|free_oh) begin
                            spawn_cnt_d = '0;
                            for (int i = 0; i < NUM_COLS; i++) begin
                                if (free_oh[i]) begin
                                    active_d[i]  = 1'b1;
                                    ypos_d[i]    = '0;
                                    letters_d[i] = spawn_letter;
                                end
                            end
                        end else begin
                            spawn_cnt_d = SPN_W'(SPAWN_GAP);
                        end
                    end else begin
                        spawn_cnt_d = spawn_cnt_q + SPN_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_SEED;
            tick_cnt_q   <= '0;
            cur_per_q    <= PER_W'(TICK_DIV_INIT);
            next_per_q   <= PER_W'(TICK_DIV_INIT);
            spawn_cnt_q  <= '0;
            spd_cnt_q    <= '0;
            armed_q      <= 1'b1;
            armed_val_q  <= '0;
            start_prev_q <= 1'b0;
            active_q     <= '0;
            score_q      <= '0;
            correct_q    <= 1'b0;
            for (int i = 0; i < NUM_COLS; i++) begin
                letters_q[i] <= '0;
                ypos_q[i]    <= '0;
            end
`ifdef FALLING_COLUMN_LIVES_EN
            lives_q      <= 4'(LIVES);
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            tick_cnt_q   <= tick_cnt_d;
            cur_per_q    <= cur_per_d;
            next_per_q   <= next_per_d;
            spawn_cnt_q  <= spawn_cnt_d;
            spd_cnt_q    <= spd_cnt_d;
            armed_q      <= armed_d;
            armed_val_q  <= armed_val_d;
            start_prev_q <= bus.start;
            active_q     <= active_d;
            score_q      <= score_d;
            correct_q    <= correct_d;
            letters_q    <= letters_d;
            ypos_q       <= ypos_d;
`ifdef FALLING_COLUMN_LIVES_EN
            lives_q      <= lives_d;
`endif
        end
    end
endmodule

// File: tb/tb_falling_column_game.sv
// Randomized bench for falling_column_game against a cycle-level behavioural model of the game rules.
// Player modes per game: eager matcher, idle (forces misses), last-moment saver (tick/match collisions).
module tb_falling_column_game;
    localparam int NC    = 3;
    localparam int BW    = 3;
    localparam int YW    = 5;
    localparam int BOT   = 5;
    localparam int TDI   = 4;
    localparam int TDM   = 2;
    localparam int STEP  = 1;
    localparam int EVERY = 2;
    localparam int GAP   = 2;
    localparam int SW    = 4;
    localparam int SMAX  = (1 << SW) - 1;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int NCYC  = 20000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    falling_column_game_if #(.NUM_COLS(NC), .BIT_WIDTH(BW), .YPOS_W(YW), .SCORE_W(SW)) bus ();

    falling_column_game #(
        .NUM_COLS(NC), .BIT_WIDTH(BW), .YPOS_W(YW), .BOTTOM_ROW(BOT),
        .TICK_DIV_INIT(TDI), .TICK_DIV_MIN(TDM), .SPEEDUP_STEP(STEP),
        .SPEEDUP_EVERY(EVERY), .SPAWN_GAP(GAP), .SCORE_W(SW), .LFSR_SEED(SEED)
    ) dut (
        .clock(clk),
        .reset_signal(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cur_cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cur_cyc, got, exp);
        end
    endtask

    // Behavioural model: 0=idle, 1=play, 2=over.
    int          m_state;
    logic [15:0] m_lfsr;
    int          m_cnt, m_cur, m_next, m_spawn, m_score, m_aval;
    bit          m_armed, m_sprev, m_correct;
    int          m_letter [NC];
    int          m_y [NC];
    bit          m_act [NC];

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic model_new_game();
        m_state = 1;
        for (int c = 0; c < NC; c++) begin
            m_letter[c] = 0;
            m_y[c]      = 0;
            m_act[c]    = 0;
        end
        m_score = 0;
        m_cnt   = 0;
        m_cur   = TDI;
        m_next  = TDI;
        m_spawn = GAP - 1;
        m_armed = 1;
        $display("game start");
    endtask

    task automatic model_step(input bit rn, input bit s, input int ui);
        int mcol, fcol, lw;
        bit tick, miss, rearm, corr;
        if (!rn) begin
            m_state = 0;
            m_lfsr  = SEED;
            m_sprev = 0;
            m_correct = 0;
            m_armed = 1;
            m_aval  = 0;
            m_score = 0;
            for (int c = 0; c < NC; c++) begin
                m_letter[c] = 0;
                m_y[c]      = 0;
                m_act[c]    = 0;
            end
            return;
        end
        corr  = 0;
        rearm = !m_armed && (ui != m_aval);
        if ((m_state == 0 && s) || (m_state == 2 && s && !m_sprev)) begin
            model_new_game();
        end else if (m_state == 1) begin
            tick = (m_cnt == m_cur - 1);
            mcol = -1;
            if (m_armed)
                for (int c = 0; c < NC; c++)
                    if (mcol < 0 && m_act[c] && m_letter[c] == ui) mcol = c;
            miss = 0;
            if (tick)
                for (int c = 0; c < NC; c++)
                    if (m_act[c] && c != mcol && m_y[c] == BOT) miss = 1;
            fcol = -1;
            for (int c = 0; c < NC; c++)
                if (fcol < 0 && !m_act[c]) fcol = c;
            if (tick) begin
                m_cnt = 0;
                m_cur = m_next;
            end else begin
                m_cnt++;
            end
            if (mcol >= 0) begin
                m_act[mcol] = 0;
                m_y[mcol]   = 0;
                corr    = 1;
                m_armed = 0;
                m_aval  = ui;
                if (m_score < SMAX) begin
                    m_score++;
                    if (m_score % EVERY == 0)
                        m_next = (m_next - STEP >= TDM) ? m_next - STEP : TDM;
                end
                $display("match col=%0d letter=%0d score=%0d", mcol, ui, m_score);
            end
            if (tick) begin
                if (miss) begin
                    m_state = 2;
                    $display("game over score=%0d", m_score);
                end else begin
                    for (int c = 0; c < NC; c++)
                        if (m_act[c]) m_y[c]++;
                    m_spawn++;
                    if (m_spawn >= GAP) begin
                        if (fcol >= 0) begin
                            lw = int'(m_lfsr) % (1 << BW);
                            m_act[fcol]    = 1;
                            m_y[fcol]      = 0;
                            m_letter[fcol] = (lw == 0) ? 1 : lw;
                            m_spawn        = 0;
                        end else begin
                            m_spawn = GAP;
                        end
                    end
                end
            end
        end
        if (rearm) m_armed = 1;
        m_sprev   = s;
        m_correct = corr;
        m_lfsr    = lfsr_next(m_lfsr);
    endtask

    initial begin
        int  mode, rst_hold, ui, prev_state, pick, n_act;
        int  act_idx [NC];
        bit  rn, st;
        logic [31:0] exp_let, exp_y, exp_act;

        mode = 0; rst_hold = 0; ui = 0; st = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.user_input = '0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            cur_cyc = cyc;
            if (cyc >= 2 && rst_hold == 0 && $urandom_range(0, 2999) == 0) rst_hold = 2;
            rn = !(cyc < 2 || rst_hold > 0);
            if (rst_hold > 0) rst_hold--;
            if (cyc >= 2 && $urandom_range(0, 5) == 0) st = !st;

            n_act = 0;
            for (int c = 0; c < NC; c++)
                if (m_act[c]) begin
                    act_idx[n_act] = c;
                    n_act++;
                end
            case (mode)
                0: begin
                    pick = $urandom_range(0, 2);
                    if (pick == 1 && n_act > 0) ui = m_letter[act_idx[$urandom_range(0, n_act - 1)]];
                    else if (pick == 2) ui = $urandom_range(0, (1 << BW) - 1);
                end
                1: ui = 0;
                default: begin
                    pick = -1;
                    if (m_state == 1 && m_cnt == m_cur - 1)
                        for (int c = 0; c < NC; c++)
                            if (m_act[c] && m_y[c] == BOT) pick = c;
                    if (pick >= 0) ui = m_letter[pick];
                    else if ($urandom_range(0, 1) == 0) ui = 0;
                end
            endcase

            rst_n = rn;
            bus.start = st;
            bus.user_input = BW'(ui);
            prev_state = m_state;
            model_step(rn, st, ui);
            if (m_state == 1 && prev_state != 1) mode = $urandom_range(0, 2);

            @(negedge clk);
            exp_let = 0; exp_y = 0; exp_act = 0;
            for (int c = 0; c < NC; c++) begin
                exp_let = exp_let | (32'(m_letter[c]) << (c * BW));
                exp_y   = exp_y   | (32'(m_y[c]) << (c * YW));
                exp_act = exp_act | (32'(m_act[c]) << c);
            end
            check_val("letters",   32'(bus.letters),   exp_let);
            check_val("ypos",      32'(bus.ypos),      exp_y);
            check_val("active",    32'(bus.active),    exp_act);
            check_val("score",     32'(bus.score),     32'(m_score));
            check_val("correct",   32'(bus.correct),   32'(m_correct));
            check_val("playing",   32'(bus.playing),   32'(m_state == 1));
            check_val("game_over", 32'(bus.game_over), 32'(m_state == 2));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/falling_column_game.md
Name: falling_column_game

Overview:
- Parametrised successor to the single-column falling-byte game controller.
- Manages NUM_COLS independent columns. Each column holds a pseudo-random target byte that falls one row per game tick.
- Adds on-chip spawning, score, speed ramp and a start/over flow.
- Sits between switches/buttons and Display/VGA: outputs packed letter and ypos buses for the display.

Parameters:
- NUM_COLS, 3, number of columns.
- BIT_WIDTH, 8, letter/user_input width (2..16).
- YPOS_W, 5, row index width.
- BOTTOM_ROW, 21, last row; a tick with a column at this row is a miss.
- TICK_DIV_INIT, 25000000, clock cycles per fall tick at start.
- TICK_DIV_MIN, 5000000, floor for the tick period.
- SPEEDUP_STEP, 1000000, period decrement per speed-up.
- SPEEDUP_EVERY, 8, points between speed-ups.
- SPAWN_GAP, 4, ticks between spawns.
- SCORE_W, 16, score width.
- LFSR_SEED, 16'hACE1, nonzero 16-bit seed.

Ports:
- clock, input, 1, system clock.
- reset_signal, input, 1, synchronous active-low reset.
- start, input, 1, level; sampled in IDLE/OVER.
- user_input, input, BIT_WIDTH, player switch value.
- letters, output, NUM_COLS*BIT_WIDTH, column c at [c*BIT_WIDTH +: BIT_WIDTH].
- ypos, output, NUM_COLS*YPOS_W, column c at [c*YPOS_W +: YPOS_W].
- active, output, NUM_COLS, column occupied.
- score, output, SCORE_W, points, saturating.
- correct, output, 1, one-cycle pulse per cleared column.
- playing, output, 1, high in PLAY.
- game_over, output, 1, high in OVER.

Behaviour:

Reset (reset_signal low at a clock edge):
- state=IDLE.
- letters, ypos, active, score = 0.
- correct, playing, game_over = 0.
- LFSR=LFSR_SEED; tick counter=0; period=TICK_DIV_INIT; spawn counter=0; match_armed=1.

State machine:
- IDLE: start=1 → PLAY. Entering PLAY clears columns/score/counters and reloads period; the LFSR keeps running.
- PLAY: tick counter counts 0..period-1; tick=1 for one cycle at wrap.
- PLAY → OVER on a miss: a tick while any active column has ypos==BOTTOM_ROW. Column state freezes in OVER.
- OVER: game_over=1. start=0 then start=1 (rising edge) → PLAY with a fresh game.

LFSR:
- 16-bit Galois, taps 16,14,13,11.
- Advances every cycle in all states.
- Spawn letter = low BIT_WIDTH bits; a value of 0 is replaced by 1.

Match:
- In PLAY, match when match_armed=1 and user_input==letter of an active column.
- Only the lowest-index matching column clears: active←0, ypos←0.
- score+1 (saturating at all-ones); correct=1 the next cycle.
- match_armed←0 on a match; re-armed in the first cycle user_input differs from the matched value. Toggling away and back is needed to clear duplicate letters.

Tick:
- Every active, non-matched column gets ypos+1.
- Spawn counter+1; when it reaches SPAWN_GAP, reset it and spawn into the lowest-index inactive column: ypos=0, letter=LFSR value.
- If no column is free, skip the spawn and keep the counter at SPAWN_GAP so the spawn retries next tick.
- The first spawn happens on the first tick of a game (counter preloaded to SPAWN_GAP-1).

Speed-up:
- When score crosses a multiple of SPEEDUP_EVERY: period ← max(period-SPEEDUP_STEP, TICK_DIV_MIN).
- Takes effect at the next tick-counter wrap.

Simultaneous events:
- Match and tick in the same cycle: the matched column neither moves nor can miss. A match on the last bottom-row column averts game over.
- A column cleared this cycle cannot be a spawn target this cycle.
- Miss and match on different columns in the same cycle: the match is scored, then OVER.

Reset mid-game: same as power-on, returns to IDLE.

Optional Feature:
- Macro FALLING_COLUMN_LIVES_EN.
- Enabled:
  - Adds parameter LIVES (default 3) and output port lives [3:0], reset/start value LIVES.
  - A miss clears every bottom-row column and decrements lives by one per tick, regardless of how many columns missed.
  - OVER is entered only when lives reaches 0.
- Disabled: no lives port; the first miss → OVER.

Test Plan:
- Test parameters: NUM_COLS=3, TICK_DIV_INIT=4, TICK_DIV_MIN=2, SPEEDUP_STEP=1, SPEEDUP_EVERY=2, SPAWN_GAP=2, BOTTOM_ROW=5.
- Reset: reset_signal=0 for 2 cycles → all outputs 0, state IDLE. Then start=1 → playing=1 next cycle; column 0 active with a nonzero letter at the first tick (cycle 4).
- Match: set user_input = column 0 letter → column 0 cleared, score=1, correct high exactly one cycle. Hold user_input → no second clear even if column 1 has the same letter until user_input toggles.
- Miss: never match → column 0 ypos reaches 5; the next tick sets game_over=1 and playing=0 with ypos frozen. start low-then-high → fresh game with score=0.
- Tick/match collision: drive the match on the exact tick cycle with column 0 at ypos=5 → no game over, score+1.
- Speed-up: score 2 → tick period 3; score 4 → 2; score 6 → stays 2.
- With FALLING_COLUMN_LIVES_EN: three misses → lives 3,2,1,0; game_over asserted only on the third miss.
